// File: rtl/addroundkey_stream.sv
// addroundkey_stream: streaming AES AddRoundKey with source select, round tagging and a 2-entry output FIFO
module addroundkey_stream #(
    parameter int DATA_W     = 128,
    parameter int NUM_SRC    = 2,
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4,
    localparam int SEL_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]         key,
    input  logic                      first,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ROUND_W-1:0]        out_round,
    output logic                      out_last,
    output logic                      done,
    output logic                      err_sel
);
    localparam logic [SEL_W:0]     SRC_LIM = (SEL_W+1)'(NUM_SRC);
    localparam logic [ROUND_W-1:0] LAST_R  = ROUND_W'(NUM_ROUNDS);

    logic [DATA_W-1:0]  slot [NUM_SRC];
    logic [1:0]         count;
    logic [DATA_W-1:0]  spare_data;
    logic [ROUND_W-1:0] spare_round;
    logic               spare_last;
    logic [ROUND_W-1:0] cnt;
    logic [ROUND_W-1:0] tag;
    logic [SEL_W-1:0]   idx;
    logic [DATA_W-1:0]  new_data;
    logic               new_last;
    logic               legal;
    logic               push;
    logic               pop;

    genvar i;
    for (i = 0; i < NUM_SRC; i++) begin : g_slot
        assign slot[i] = src_data[i*DATA_W +: DATA_W];
    end

    assign in_ready  = rst & (count != 2'd2);
    assign out_valid = count != 2'd0;

    // Beat formation: illegal selects index slot 0 and force zero data so no unselected slot leaks in
    always_comb begin
        legal    = {1'b0, sel} < SRC_LIM;
        idx      = legal ? sel : '0;
        new_data = legal ? (slot[idx] ^ key) : '0;
        tag      = first ? '0 : cnt;
        new_last = tag == LAST_R;
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
    end

    // Output FIFO: head lives directly in the output registers, spare holds the second entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            out_data    <= '0;
            out_round   <= '0;
            out_last    <= 1'b0;
            spare_data  <= '0;
            spare_round <= '0;
            spare_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (push && (count == 2'd0 || pop)) begin
                out_data  <= new_data;
                out_round <= tag;
                out_last  <= new_last;
            end else if (pop && count == 2'd2) begin
                out_data  <= spare_data;
                out_round <= spare_round;
                out_last  <= spare_last;
            end
            if (push && !pop && count == 2'd1) begin
                spare_data  <= new_data;
                spare_round <= tag;
                spare_last  <= new_last;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            done  <= pop & out_last;
        end
    end

    // Round counter wraps after the final round; err_sel latches any illegal select until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            err_sel <= 1'b0;
        end else if (push) begin
            cnt     <= new_last ? '0 : tag + 1'b1;
            err_sel <= err_sel | ~legal;
        end
    end
endmodule
